// File: rtl/key_step_pkg.sv
// Shared constants for the single-step key front end: FSM encodings and
// default debounce / step-pulse timing for simulation and for the board.
package key_step_pkg;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DB_PRESS   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] DB_RELEASE = 2'd3;

  localparam logic [15:0] SIM_DB_CYCLES   = 16'd4;
  localparam logic [7:0]  SIM_PULSE_W     = 8'd2;
  localparam logic [15:0] BOARD_DB_CYCLES = 16'd50000;
  localparam logic [7:0]  BOARD_PULSE_W   = 8'd4;

  // The debounced level is high once a press has been accepted and until
  // its release has been accepted.
  function automatic logic key_level(input logic [1:0] st);
    return (st == HELD) || (st == DB_RELEASE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages clear to 0
// on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// Debounces a raw push-button into a clean level with press/release strobes,
// and issues a fixed-width step clock pulse plus a step count on each press.
module key_step_gen
  import key_step_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = BOARD_DB_CYCLES,
  parameter logic [7:0]  PULSE_W   = BOARD_PULSE_W,
  parameter int          CNT_W     = 8
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             key_xi,
  output logic             key_xo,
  output logic             press_xo,
  output logic             release_xo,
  output logic             step_clk_xo,
  output logic [CNT_W-1:0] step_cnt_xo,
  output logic [1:0]       state_dbg
);

  logic        key_s;
  logic [1:0]  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [7:0]  pcnt;
  logic        press_evt, release_evt;

  sync_2ff u_sync (
    .clk (clka),
    .rst (rsta),
    .d   (key_xi),
    .q   (key_s)
  );

  // The debounce counter restarts from zero on every state entry, so a
  // bounce always costs a full fresh window.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nx = DB_PRESS;
          cnt_nx   = 16'd0;
        end
      end
      DB_PRESS: begin
        if (!key_s) begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
        end else if (cnt == DB_CYCLES - 16'd1) begin
          state_nx = HELD;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_nx = DB_RELEASE;
          cnt_nx   = 16'd0;
        end
      end
      DB_RELEASE: begin
        if (key_s) begin
          state_nx = HELD;
          cnt_nx   = 16'd0;
        end else if (cnt == DB_CYCLES - 16'd1) begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 16'd0;
      end
    endcase
  end

  assign press_evt   = (state == DB_PRESS)   && (state_nx == HELD);
  assign release_evt = (state == DB_RELEASE) && (state_nx == IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      key_xo     <= 1'b0;
      press_xo   <= 1'b0;
      release_xo <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      key_xo     <= key_level(state_nx);
      press_xo   <= press_evt;
      release_xo <= release_evt;
    end
  end

  // Pulse launches on the same edge as press_xo; pcnt holds the remaining
  // high cycles after the current one.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      step_clk_xo <= 1'b0;
      pcnt        <= 8'd0;
      step_cnt_xo <= '0;
    end else begin
      if (press_evt) begin
        step_clk_xo <= 1'b1;
        pcnt        <= PULSE_W - 8'd1;
        step_cnt_xo <= step_cnt_xo + CNT_W'(1);
      end else if (step_clk_xo) begin
        if (pcnt != 8'd0) pcnt <= pcnt - 8'd1;
        else              step_clk_xo <= 1'b0;
      end
    end
  end

  a_no_pulse_restart: assert property (@(posedge clka) disable iff (rsta)
    !(press_evt && step_clk_xo));

  a_strobes_exclusive: assert property (@(posedge clka) disable iff (rsta)
    !(press_xo && release_xo));

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen: debounce timing, bounce rejection, step
// pulse, counter wrap, async reset and fast toggling.
module tb_key_step_gen;
  import key_step_pkg::*;

  localparam logic [7:0] PW = SIM_PULSE_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic       key2 = 1'b0;
  logic       key_o, press_o, release_o, step_o;
  logic [7:0] cnt_o;
  logic [1:0] st_o;
  logic       key2_o, press2_o, release2_o, step2_o;
  logic [1:0] cnt2_o;
  logic [1:0] st2_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  int   press_n = 0, release_n = 0, pulse_n = 0, pulse2_n = 0;
  int   run = 0, bad_width = 0, both_strobe = 0, state_bad = 0;
  logic step_q = 1'b0, step2_q = 1'b0;
  logic watch = 1'b0;
  logic [7:0] exp_q[$];

  key_step_gen #(.DB_CYCLES(SIM_DB_CYCLES), .PULSE_W(SIM_PULSE_W), .CNT_W(8)) u_dut (
    .clka(clk), .rsta(rst), .key_xi(key), .key_xo(key_o), .press_xo(press_o),
    .release_xo(release_o), .step_clk_xo(step_o), .step_cnt_xo(cnt_o), .state_dbg(st_o)
  );

  key_step_gen #(.DB_CYCLES(SIM_DB_CYCLES), .PULSE_W(SIM_PULSE_W), .CNT_W(2)) u_dut_w2 (
    .clka(clk), .rsta(rst), .key_xi(key2), .key_xo(key2_o), .press_xo(press2_o),
    .release_xo(release2_o), .step_clk_xo(step2_o), .step_cnt_xo(cnt2_o), .state_dbg(st2_o)
  );

  always #5 clk = ~clk;

  // Event monitor: strobe/pulse counts and pulse width, sampled mid-cycle.
  always @(negedge clk) begin
    step_q  <= step_o;
    step2_q <= step2_o;
    if (press_o)            press_n   <= press_n + 1;
    if (release_o)          release_n <= release_n + 1;
    if (step_o && !step_q)  pulse_n   <= pulse_n + 1;
    if (step2_o && !step2_q) pulse2_n <= pulse2_n + 1;
    if (press_o && release_o) both_strobe <= both_strobe + 1;
    if (watch && (st_o == HELD || st_o == DB_RELEASE)) state_bad <= state_bad + 1;
    if (rst) run <= 0;
    else if (step_o) run <= run + 1;
    else if (run != 0) begin
      if (run != int'(PW)) bad_width <= bad_width + 1;
      run <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    key = 1'b0; key2 = 1'b0; rst = 1'b1;
    tick(3);
    total_cnt++; if ({key_o, press_o, release_o, step_o} !== 4'b0) $display("FAIL reset_bits got %b want 0000", {key_o, press_o, release_o, step_o}); else pass_cnt++;
    total_cnt++; if (cnt_o !== 8'd0) $display("FAIL reset_cnt got %0d want 0", cnt_o); else pass_cnt++;
    total_cnt++; if (st_o !== IDLE) $display("FAIL reset_state got %0d want 0", st_o); else pass_cnt++;
    rst = 1'b0;
    tick(3);
    total_cnt++; if ({key_o, press_o, step_o, cnt_o, cnt2_o} !== 13'b0) $display("FAIL post_reset_idle got %b want 0", {key_o, press_o, step_o, cnt_o, cnt2_o}); else pass_cnt++;
  endtask

  task automatic test_clean_press();
    key = 1'b1;
    tick(6);
    total_cnt++; if ({key_o, press_o} !== 2'b00) $display("FAIL clean_early got %b want 00", {key_o, press_o}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({key_o, press_o, step_o} !== 3'b111) $display("FAIL clean_rise got %b want 111", {key_o, press_o, step_o}); else pass_cnt++;
    total_cnt++; if (cnt_o !== 8'd1) $display("FAIL clean_cnt_at_press got %0d want 1", cnt_o); else pass_cnt++;
    tick(1);
    total_cnt++; if ({press_o, step_o} !== 2'b01) $display("FAIL clean_edge7 got %b want 01", {press_o, step_o}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({step_o, cnt_o} !== {1'b0, 8'd1}) $display("FAIL clean_edge8 got step=%b cnt=%0d want step=0 cnt=1", step_o, cnt_o); else pass_cnt++;
    key = 1'b0;
    tick(10);
    total_cnt++; if ({key_o, st_o} !== {1'b0, IDLE}) $display("FAIL clean_release got key=%b st=%0d want key=0 st=0", key_o, st_o); else pass_cnt++;
  endtask

  task automatic test_bounce();
    int p0;
    p0 = press_n;
    key = 1'b1; tick(3);
    key = 1'b0; tick(2);
    key = 1'b1; tick(3);
    key = 1'b0; tick(8);
    total_cnt++; if (press_n !== p0) $display("FAIL bounce_no_press got %0d want %0d", press_n, p0); else pass_cnt++;
    total_cnt++; if ({key_o, cnt_o} !== {1'b0, 8'd1}) $display("FAIL bounce_level got key=%b cnt=%0d want key=0 cnt=1", key_o, cnt_o); else pass_cnt++;
    key = 1'b1; tick(10);
    total_cnt++; if (press_n !== p0 + 1) $display("FAIL bounce_then_hold got %0d want %0d", press_n, p0 + 1); else pass_cnt++;
    total_cnt++; if ({key_o, cnt_o} !== {1'b1, 8'd2}) $display("FAIL bounce_hold_level got key=%b cnt=%0d want key=1 cnt=2", key_o, cnt_o); else pass_cnt++;
  endtask

  task automatic test_release();
    int r0, pu0;
    r0 = release_n; pu0 = pulse_n;
    key = 1'b0; tick(2);
    key = 1'b1; tick(2);
    key = 1'b0;
    tick(6);
    total_cnt++; if ({key_o, release_o} !== 2'b10) $display("FAIL release_early got %b want 10", {key_o, release_o}); else pass_cnt++;
    tick(1);
    total_cnt++; if ({key_o, release_o} !== 2'b01) $display("FAIL release_edge got %b want 01", {key_o, release_o}); else pass_cnt++;
    tick(1);
    total_cnt++; if (release_o !== 1'b0) $display("FAIL release_one_cycle got %b want 0", release_o); else pass_cnt++;
    tick(4);
    total_cnt++; if (release_n !== r0 + 1) $display("FAIL release_count got %0d want %0d", release_n, r0 + 1); else pass_cnt++;
    total_cnt++; if (pulse_n !== pu0) $display("FAIL release_no_pulse got %0d want %0d", pulse_n, pu0); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    logic [7:0] wrap_exp[5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) exp_q.push_back(wrap_exp[i]);
    for (int i = 0; i < 5; i++) begin
      key2 = 1'b1;
      tick(7);
      exp = exp_q.pop_front();
      total_cnt++; if ({press2_o, 6'd0, cnt2_o} !== {1'b1, exp}) $display("FAIL wrap_press%0d got press=%b cnt=%0d want press=1 cnt=%0d", i, press2_o, cnt2_o, exp); else pass_cnt++;
      tick(3);
      key2 = 1'b0;
      tick(10);
    end
    total_cnt++; if (pulse2_n !== 5) $display("FAIL wrap_pulses got %0d want 5", pulse2_n); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int r0;
    key = 1'b1;
    tick(7);
    total_cnt++; if (step_o !== 1'b1) $display("FAIL mid_pulse_high got %b want 1", step_o); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({key_o, press_o, release_o, step_o, cnt_o} !== 12'd0) $display("FAIL mid_reset_async got %b want 0", {key_o, press_o, release_o, step_o, cnt_o}); else pass_cnt++;
    r0 = release_n;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(6);
    total_cnt++; if (press_o !== 1'b0) $display("FAIL mid_early_press got %b want 0", press_o); else pass_cnt++;
    tick(1);
    total_cnt++; if ({press_o, step_o, cnt_o} !== {2'b11, 8'd1}) $display("FAIL mid_repress got press=%b step=%b cnt=%0d want 1 1 1", press_o, step_o, cnt_o); else pass_cnt++;
    total_cnt++; if (release_n !== r0) $display("FAIL mid_no_release got %0d want %0d", release_n, r0); else pass_cnt++;
    key = 1'b0;
    tick(12);
  endtask

  task automatic test_toggle();
    int p0, r0, pu0;
    p0 = press_n; r0 = release_n; pu0 = pulse_n;
    watch = 1'b1;
    for (int i = 0; i < 100; i++) begin
      key = ~key;
      tick(1);
    end
    key = 1'b0;
    tick(8);
    watch = 1'b0;
    total_cnt++; if ({press_n, release_n, pulse_n} !== {p0, r0, pu0}) $display("FAIL toggle_strobes got %0d/%0d/%0d want %0d/%0d/%0d", press_n, release_n, pulse_n, p0, r0, pu0); else pass_cnt++;
    total_cnt++; if (state_bad !== 0) $display("FAIL toggle_states got %0d want 0", state_bad); else pass_cnt++;
  endtask

  task automatic test_invariants();
    total_cnt++; if (bad_width !== 0) $display("FAIL pulse_width got %0d bad pulses want 0", bad_width); else pass_cnt++;
    total_cnt++; if (both_strobe !== 0) $display("FAIL strobe_overlap got %0d want 0", both_strobe); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_counter_wrap();
    test_reset_mid();
    test_toggle();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
